// File: rtl/gate_check_pkg.sv
// Shared types and the golden truth table for the two-input, eight-output gate block checker.
package gate_check_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    localparam int unsigned NUM_VECTORS = 4;

    localparam int unsigned S1_IDX = 0;
    localparam int unsigned S2_IDX = 1;
    localparam int unsigned S3_IDX = 2;
    localparam int unsigned S4_IDX = 3;
    localparam int unsigned S5_IDX = 4;
    localparam int unsigned S6_IDX = 5;
    localparam int unsigned S7_IDX = 6;
    localparam int unsigned S8_IDX = 7;

    function automatic logic [7:0] golden(input logic a, input logic b);
        logic [7:0] s;
        s         = '0;
        s[S1_IDX] = a & b;
        s[S2_IDX] = a | b;
        s[S3_IDX] = ~a;
        s[S4_IDX] = ~(a & b);
        s[S5_IDX] = ~(a | b);
        s[S6_IDX] = a ^ b;
        s[S7_IDX] = ~(a ^ b);
        s[S8_IDX] = ~b;
        return s;
    endfunction

endpackage

// File: rtl/gate_vec_seq.sv
// Vector sequencer: walks {A,B} through 00..11, holding each for DWELL cycles, and
// strobes when to sample S and when the final vector has finished its dwell.
module gate_vec_seq
    import gate_check_pkg::*;
#(
    parameter int unsigned DWELL  = 50,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       launch,
    input  logic       run,
    output logic       A,
    output logic       B,
    output logic [1:0] idx,
    output logic       sample_now,
    output logic       last_vec
);

    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CntSample = CNT_W'(SETTLE);
    localparam logic [1:0]       IdxLast   = 2'(NUM_VECTORS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       ab_q, ab_d;
    logic             dwell_end;

    assign dwell_end  = run && (cnt_q == CntLast);
    assign sample_now = run && (cnt_q == CntSample);
    assign last_vec   = dwell_end && (idx_q == IdxLast);

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        ab_d  = ab_q;
        if (launch) begin
            cnt_d = '0;
            idx_d = '0;
            ab_d  = '0;
        end else if (run) begin
            if (dwell_end) begin
                cnt_d = '0;
                if (idx_q != IdxLast) begin
                    idx_d = idx_q + 2'd1;
                    ab_d  = idx_q + 2'd1;
                end else begin
                    // Inputs drop back to 00 while the run wraps up.
                    ab_d = '0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            ab_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            ab_q  <= ab_d;
        end
    end

    assign A   = ab_q[1];
    assign B   = ab_q[0];
    assign idx = idx_q;

endmodule

// File: rtl/gate_truth_checker.sv
// Self-contained stimulus and check stage for the eight-output gate block: runs all four
// input vectors, compares S against the golden table and accumulates the results.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned DWELL  = 50,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic [7:0] S,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [7:0] mismatch_bits
);

    state_t     state_q, state_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic [7:0] mm_q, mm_d;
    logic       pass_q, pass_d;

    logic       launch, run, sample_now, last_vec;
    logic [1:0] idx;
    logic [7:0] diff;

    assign launch = (state_q == StIdle) && start;
    assign run    = (state_q == StRun);

    gate_vec_seq #(
        .DWELL (DWELL),
        .SETTLE(SETTLE),
        .CNT_W (CNT_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (launch),
        .run       (run),
        .A         (A),
        .B         (B),
        .idx       (idx),
        .sample_now(sample_now),
        .last_vec  (last_vec)
    );

    // Expected value comes from the vector index, which always matches the driven A/B.
    assign diff = S ^ golden(idx[1], idx[0]);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fail_d  = fail_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    err_d   = '0;
                    fail_d  = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            StRun: begin
                if (sample_now && (diff != 8'h00)) begin
                    fail_d[idx] = 1'b1;
                    err_d       = err_q + 3'd1;
                    mm_d        = mm_q | diff;
                end
                // Uses err_d so a compare on the final dwell cycle is still counted.
                if (last_vec) begin
                    state_d = StDone;
                    pass_d  = (err_d == 3'd0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= '0;
            fail_q  <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign fail_mask     = fail_q;
    assign mismatch_bits = mm_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: two checkers (DWELL 50/SETTLE 2 and DWELL 3/SETTLE 1) driving a
// behavioural gate block with injectable faults.
module tb_gate_truth_checker;

    localparam int DW0 = 50;
    localparam int DW1 = 3;

    typedef struct {
        int         t_start;
        logic [2:0] cnt;
        logic [3:0] mask;
        logic [7:0] mm;
        logic       ps;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_r [2];
    logic       a [2];
    logic       b [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [2:0] errc [2];
    logic [3:0] fmask [2];
    logic [7:0] mmb [2];
    logic [7:0] s_in [2];
    logic [7:0] s0 [2];
    logic [7:0] s1 [2];
    logic [31:0] flip [2];

    exp_t exp_q [2][$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Truth table derived arithmetically from the gate definitions.
    function automatic logic [7:0] tb_gold(input logic [1:0] v);
        int x, y;
        logic [7:0] r;
        x = int'(v[1]);
        y = int'(v[0]);
        r[0] = (x * y) == 1;
        r[1] = (x + y) > 0;
        r[2] = x == 0;
        r[3] = (x * y) == 0;
        r[4] = (x + y) == 0;
        r[5] = (x + y) == 1;
        r[6] = (x + y) != 1;
        r[7] = y == 0;
        return r;
    endfunction

    function automatic logic [7:0] faulty(input logic [1:0] v, input logic [7:0] f0,
                                          input logic [7:0] f1, input logic [31:0] fl);
        return ((tb_gold(v) & ~f0) | f1) ^ fl[int'(v) * 8 +: 8];
    endfunction

    function automatic exp_t model(input int t, input logic [7:0] f0, input logic [7:0] f1,
                                   input logic [31:0] fl);
        exp_t e;
        logic [7:0] x;
        e.t_start = t;
        e.cnt = '0;
        e.mask = '0;
        e.mm = '0;
        for (int v = 0; v < 4; v++) begin
            x = faulty(2'(v), f0, f1, fl) ^ tb_gold(2'(v));
            if (x != 8'h00) begin
                e.mask[v] = 1'b1;
                e.cnt = e.cnt + 3'd1;
                e.mm = e.mm | x;
            end
        end
        e.ps = (e.cnt == 3'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DW = (g == 0) ? DW0 : DW1;
        localparam int ST = (g == 0) ? 2 : 1;

        gate_truth_checker #(
            .DWELL (DW),
            .SETTLE(ST),
            .CNT_W (8)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start_r[g]),
            .A            (a[g]),
            .B            (b[g]),
            .S            (s_in[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .pass         (pass[g]),
            .err_count    (errc[g]),
            .fail_mask    (fmask[g]),
            .mismatch_bits(mmb[g])
        );

        assign s_in[g] = faulty({a[g], b[g]}, s0[g], s1[g], flip[g]);

        initial begin : mon
            exp_t e;
            int   k;
            forever begin
                @(negedge clk);
                if (rst_n && exp_q[g].size() > 0) begin
                    e = exp_q[g][0];
                    k = cyc - e.t_start;
                    if (done[g]) begin
                        chk("done_cycle", cyc, e.t_start + 4 * DW);
                        chk("busy_at_done", busy[g], 1);
                        chk("err_count", errc[g], e.cnt);
                        chk("fail_mask", fmask[g], e.mask);
                        chk("mismatch_bits", mmb[g], e.mm);
                        chk("pass", pass[g], e.ps);
                        void'(exp_q[g].pop_front());
                    end else if (k >= 0 && k < 4 * DW) begin
                        chk("ab_vector", {a[g], b[g]}, k / DW);
                        chk("busy_in_run", busy[g], 1);
                    end
                end else if (rst_n && done[g]) begin
                    chk("unexpected_done", done[g], 0);
                end
            end
        end
    end

    task automatic set_fault(input int g, input logic [7:0] f0, input logic [7:0] f1,
                             input logic [31:0] fl);
        s0[g] = f0;
        s1[g] = f1;
        flip[g] = fl;
    endtask

    task automatic wait_empty(input int g, input int limit);
        for (int i = 0; i < limit && exp_q[g].size() != 0; i++) @(negedge clk);
        if (exp_q[g].size() != 0) begin
            chk("run_timeout", exp_q[g].size(), 0);
            exp_q[g].delete();
        end
    endtask

    // One run with a pulsed start; noise toggles start while busy, which must be ignored.
    task automatic do_run(input int g, input logic [7:0] f0, input logic [7:0] f1,
                          input logic [31:0] fl, input bit noise);
        int t, dw;
        dw = (g == 0) ? DW0 : DW1;
        set_fault(g, f0, f1, fl);
        @(negedge clk);
        start_r[g] = 1'b1;
        t = cyc + 1;
        exp_q[g].push_back(model(t, f0, f1, fl));
        @(negedge clk);
        start_r[g] = 1'b0;
        if (noise) begin
            while (cyc < t + 4 * dw - 2) begin
                start_r[g] = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            start_r[g] = 1'b0;
        end
        wait_empty(g, 4 * dw + 20);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input int g);
        chk("rst_A", a[g], 0);
        chk("rst_B", b[g], 0);
        chk("rst_busy", busy[g], 0);
        chk("rst_done", done[g], 0);
        chk("rst_pass", pass[g], 0);
        chk("rst_err_count", errc[g], 0);
        chk("rst_fail_mask", fmask[g], 0);
        chk("rst_mismatch_bits", mmb[g], 0);
    endtask

    initial begin
        int t;
        logic [31:0] fl;
        for (int g = 0; g < 2; g++) begin
            start_r[g] = 1'b0;
            set_fault(g, 8'h00, 8'h00, 32'h0);
        end
        #1;
        check_reset_values(0);
        check_reset_values(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct gate block, then S6 stuck at 0, then S forced to all ones.
        do_run(0, 8'h00, 8'h00, 32'h0, 1'b0);
        do_run(0, 8'h20, 8'h00, 32'h0, 1'b1);
        do_run(0, 8'h00, 8'hFF, 32'h0, 1'b0);

        // Short dwell, only vector 11 faulty with S1 low.
        do_run(1, 8'h00, 8'h00, 32'h0100_0000, 1'b0);

        // Reset 120 cycles into a run.
        set_fault(0, 8'h00, 8'h00, 32'h0);
        @(negedge clk);
        start_r[0] = 1'b1;
        t = cyc + 1;
        exp_q[0].push_back(model(t, 8'h00, 8'h00, 32'h0));
        @(negedge clk);
        start_r[0] = 1'b0;
        for (int i = 0; i < 200 && cyc < t + 120; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q[0].delete();
        check_reset_values(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * DW0 + 10) @(negedge clk);
        chk("idle_after_reset_busy", busy[0], 0);
        do_run(0, 8'h00, 8'h00, 32'h0, 1'b0);

        // start held high: two back-to-back runs, one idle cycle between them.
        set_fault(0, 8'h00, 8'h00, 32'h0);
        @(negedge clk);
        start_r[0] = 1'b1;
        t = cyc + 1;
        exp_q[0].push_back(model(t, 8'h00, 8'h00, 32'h0));
        exp_q[0].push_back(model(t + 4 * DW0 + 2, 8'h00, 8'h00, 32'h0));
        for (int i = 0; i < 500 && cyc < t + 4 * DW0 + 3; i++) @(negedge clk);
        start_r[0] = 1'b0;
        wait_empty(0, 4 * DW0 + 20);
        @(negedge clk);

        // Random per-vector faults on both checkers.
        for (int r = 0; r < 8; r++) begin
            fl = 32'h0;
            for (int v = 0; v < 4; v++)
                if ($urandom_range(0, 1) == 1) fl[v * 8 +: 8] = 8'($urandom_range(0, 255));
            do_run(r % 2, 8'h00, 8'h00, fl, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
